// File: rtl/pa_regframe_pkg.sv
// pa_regframe_pkg
// Shared opcode constants, controller state encoding and opcode decode
// helpers for the register-frame spill/fill controller.
// No ports.
package pa_regframe_pkg;

  localparam logic [6:0] OP_PUSH_A = 7'd11;
  localparam logic [6:0] OP_POP_A  = 7'd12;
  localparam logic [6:0] OP_PUSH_B = 7'd13;
  localparam logic [6:0] OP_POP_B  = 7'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } rfc_state_e;

  function automatic logic is_push(input logic [6:0] op);
    return (op == OP_PUSH_A) || (op == OP_PUSH_B);
  endfunction

  function automatic logic is_pop(input logic [6:0] op);
    return (op == OP_POP_A) || (op == OP_POP_B);
  endfunction

endpackage

// File: rtl/regframe_xfer_seq.sv
// regframe_xfer_seq
// Walks register index 0..2**IDX_W-1 for one frame transfer. The request
// is held with a stable index until ack; the next index is requested in the
// cycle after the ack, so back-to-back acks give one register per cycle.
// Ports:
//   clock_i, reset_i  clock and synchronous active-high reset
//   start             one-cycle pulse, begins a transfer at index 0
//   ack               memory completed the current request this cycle
//   req               memory request, registered
//   idx               register index of the current request
//   done              ack of the last index (combinational pulse)
module regframe_xfer_seq #(
  parameter int IDX_W = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start,
  input  logic             ack,
  output logic             req,
  output logic [IDX_W-1:0] idx,
  output logic             done
);

  logic last;

  assign last = (idx == {IDX_W{1'b1}});
  assign done = req & ack & last;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      req <= 1'b0;
      idx <= '0;
    end else if (start) begin
      req <= 1'b1;
      idx <= '0;
    end else if (req && ack) begin
      if (last) req <= 1'b0;
      else      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/reg_frame_spill_ctrl.sv
// reg_frame_spill_ctrl
// Register-window frame controller. Tracks logical frame depth and how many
// frames are resident in the physical banks; spills the oldest resident
// frame to memory when a push finds every bank occupied, and fills the
// previous frame back from memory when a pop leaves no resident frame.
// Optional statistics counters are built when RFC_STATS_EN is defined;
// otherwise spillCount_o/fillCount_o are tied to zero.
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   enable_i, opCode_i      frame op valid / opcode (11,13 push; 12,14 pop)
//   stall_o                 controller busy with a spill or fill
//   regBankSelect_o         logical frame depth
//   physBank_o              active physical bank (depth mod PHYS_BANKS)
//   rfAddr_o, rfData_i      RF transfer address {bank,idx} / read data
//   rfWrEn_o, rfWrData_o    RF write strobe and data during fill
//   memReq_o, memWe_o       memory request / write enable
//   memAddr_o, memData_o    memory address / store data
//   memData_i, memAck_i     load data / request completed
//   overflow_o, underflow_o sticky error flags
//   spillCount_o, fillCount_o completed spill/fill statistics
//
// state | meaning
// IDLE  | accepting frame ops
// SPILL | writing oldest resident frame to the spill area
// FILL  | reading previous frame back into its bank
module reg_frame_spill_ctrl
  import pa_regframe_pkg::*;
#(
  parameter int PHYS_BANKS    = 8,
  parameter int REGS_PER_BANK = 16,
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] SPILL_BASE = 16'hF000,
  localparam int PB_W  = $clog2(PHYS_BANKS),
  localparam int IDX_W = $clog2(REGS_PER_BANK)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [6:0]            opCode_i,
  output logic                  stall_o,
  output logic [5:0]            regBankSelect_o,
  output logic [PB_W-1:0]       physBank_o,
  output logic [PB_W+IDX_W-1:0] rfAddr_o,
  input  logic [DATA_W-1:0]     rfData_i,
  output logic                  rfWrEn_o,
  output logic [DATA_W-1:0]     rfWrData_o,
  output logic                  memReq_o,
  output logic                  memWe_o,
  output logic [ADDR_W-1:0]     memAddr_o,
  output logic [DATA_W-1:0]     memData_o,
  input  logic [DATA_W-1:0]     memData_i,
  input  logic                  memAck_i,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [15:0]           spillCount_o,
  output logic [15:0]           fillCount_o
);

  localparam logic [5:0]  DEPTH_MAX = 6'd63;
  localparam logic [PB_W:0] RES_ONE  = (PB_W+1)'(1);
  localparam logic [PB_W:0] RES_FULL = (PB_W+1)'(PHYS_BANKS);
  // Oldest resident frame when all banks are full: depth + 1 - PHYS_BANKS.
  localparam logic [5:0]  SPILL_OFS = 6'(PHYS_BANKS - 1);

  rfc_state_e        state;
  logic              stall_q;
  logic              start_q;
  logic [5:0]        depth;
  logic [PB_W:0]     resident;
  logic [5:0]        xfer_frame;
  logic              overflow_q;
  logic              underflow_q;
  logic              seq_req;
  logic              seq_done;
  logic [IDX_W-1:0]  seq_idx;
  logic              in_spill;
  logic              in_fill;
  logic [ADDR_W-1:0] xfer_addr;

  regframe_xfer_seq #(.IDX_W(IDX_W)) u_seq (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start   (start_q),
    .ack     (memAck_i),
    .req     (seq_req),
    .idx     (seq_idx),
    .done    (seq_done)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      stall_q     <= 1'b0;
      start_q     <= 1'b0;
      depth       <= '0;
      resident    <= RES_ONE;
      xfer_frame  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            if (is_push(opCode_i)) begin
              if (depth == DEPTH_MAX) begin
                overflow_q <= 1'b1;
              end else if (resident != RES_FULL) begin
                depth    <= depth + 6'd1;
                resident <= resident + RES_ONE;
              end else begin
                state      <= ST_SPILL;
                stall_q    <= 1'b1;
                start_q    <= 1'b1;
                xfer_frame <= depth - SPILL_OFS;
              end
            end else if (is_pop(opCode_i)) begin
              if (depth == 6'd0) begin
                underflow_q <= 1'b1;
              end else if (resident != RES_ONE) begin
                depth    <= depth - 6'd1;
                resident <= resident - RES_ONE;
              end else begin
                state      <= ST_FILL;
                stall_q    <= 1'b1;
                start_q    <= 1'b1;
                xfer_frame <= depth - 6'd1;
              end
            end
          end
        end
        ST_SPILL: begin
          if (seq_done) begin
            state   <= ST_IDLE;
            stall_q <= 1'b0;
            depth   <= depth + 6'd1;
          end
        end
        ST_FILL: begin
          if (seq_done) begin
            state    <= ST_IDLE;
            stall_q  <= 1'b0;
            depth    <= depth - 6'd1;
            resident <= RES_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_spill = (state == ST_SPILL);
  assign in_fill  = (state == ST_FILL);

  assign xfer_addr = SPILL_BASE + (ADDR_W'(xfer_frame) << IDX_W) + ADDR_W'(seq_idx);

  assign stall_o         = stall_q;
  assign regBankSelect_o = depth;
  assign physBank_o      = depth[PB_W-1:0];
  assign overflow_o      = overflow_q;
  assign underflow_o     = underflow_q;

  // Transfer-side outputs are forced to zero whenever no transfer is active.
  assign rfAddr_o   = stall_q ? {xfer_frame[PB_W-1:0], seq_idx} : '0;
  assign memReq_o   = seq_req;
  assign memWe_o    = in_spill & seq_req;
  assign memAddr_o  = seq_req ? xfer_addr : '0;
  assign memData_o  = (in_spill && seq_req) ? rfData_i : '0;
  assign rfWrEn_o   = in_fill & seq_req & memAck_i;
  assign rfWrData_o = (in_fill && seq_req && memAck_i) ? memData_i : '0;

`ifdef RFC_STATS_EN
  logic [15:0] spill_cnt;
  logic [15:0] fill_cnt;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      spill_cnt <= '0;
      fill_cnt  <= '0;
    end else begin
      if (in_spill && seq_done && (spill_cnt != 16'hFFFF)) spill_cnt <= spill_cnt + 16'd1;
      if (in_fill && seq_done && (fill_cnt != 16'hFFFF))   fill_cnt  <= fill_cnt + 16'd1;
    end
  end

  assign spillCount_o = spill_cnt;
  assign fillCount_o  = fill_cnt;
`else
  assign spillCount_o = '0;
  assign fillCount_o  = '0;
`endif

endmodule

// File: tb/tb_reg_frame_spill_ctrl.sv
// Directed bench for reg_frame_spill_ctrl with 4 banks of 16 registers.
// The RF is modelled as a fixed pattern (16'hA500 + rfAddr); the memory is a
// 4K-word array answering requests after a programmable random delay.
module tb_reg_frame_spill_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [6:0]  opCode_i;
  logic        stall_o;
  logic [5:0]  regBankSelect_o;
  logic [1:0]  physBank_o;
  logic [5:0]  rfAddr_o;
  logic [15:0] rfData_i;
  logic        rfWrEn_o;
  logic [15:0] rfWrData_o;
  logic        memReq_o;
  logic        memWe_o;
  logic [15:0] memAddr_o;
  logic [15:0] memData_o;
  logic [15:0] memData_i;
  logic        memAck_i;
  logic        overflow_o;
  logic        underflow_o;
  logic [15:0] spillCount_o;
  logic [15:0] fillCount_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem    [0:4095];
  logic [15:0] rf_log [0:63];

  int max_delay  = 0;
  int wait_left  = 0;
  int ack_seq    = 0;
  int mem_wr_cnt = 0;
  int rf_wr_cnt  = 0;
  int addr_err   = 0;
  int stab_err   = 0;
  logic [15:0] exp_base = 16'hF000;

  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we  = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  reg_frame_spill_ctrl #(
    .PHYS_BANKS    (4),
    .REGS_PER_BANK (16),
    .DATA_W        (16),
    .ADDR_W        (16),
    .SPILL_BASE    (16'hF000)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .opCode_i        (opCode_i),
    .stall_o         (stall_o),
    .regBankSelect_o (regBankSelect_o),
    .physBank_o      (physBank_o),
    .rfAddr_o        (rfAddr_o),
    .rfData_i        (rfData_i),
    .rfWrEn_o        (rfWrEn_o),
    .rfWrData_o      (rfWrData_o),
    .memReq_o        (memReq_o),
    .memWe_o         (memWe_o),
    .memAddr_o       (memAddr_o),
    .memData_o       (memData_o),
    .memData_i       (memData_i),
    .memAck_i        (memAck_i),
    .overflow_o      (overflow_o),
    .underflow_o     (underflow_o),
    .spillCount_o    (spillCount_o),
    .fillCount_o     (fillCount_o)
  );

  always #5 clock_i = ~clock_i;

  assign rfData_i = 16'hA500 + 16'(rfAddr_o);

  // Memory responder and transfer monitor, working on the falling edge.
  always @(negedge clock_i) begin
    if (prev_req && !prev_ack && memReq_o) begin
      if (memAddr_o !== prev_addr || memData_o !== prev_data || memWe_o !== prev_we)
        stab_err++;
    end
    if (memReq_o) begin
      if (wait_left == 0) begin
        memAck_i  = 1'b1;
        memData_i = mem[memAddr_o[11:0]];
        wait_left = $urandom_range(max_delay, 0);
      end else begin
        memAck_i = 1'b0;
        wait_left--;
      end
    end else begin
      memAck_i  = 1'b0;
      wait_left = $urandom_range(max_delay, 0);
    end
    #1;
    if (memReq_o && memAck_i) begin
      if (memAddr_o !== exp_base + 16'(ack_seq)) addr_err++;
      ack_seq++;
      if (memWe_o) begin
        mem[memAddr_o[11:0]] = memData_o;
        mem_wr_cnt++;
      end
    end
    if (rfWrEn_o === 1'b1) begin
      rf_log[rfAddr_o] = rfWrData_o;
      rf_wr_cnt++;
    end
    prev_req  = memReq_o;
    prev_ack  = memAck_i;
    prev_we   = memWe_o;
    prev_addr = memAddr_o;
    prev_data = memData_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input logic [6:0] op);
    enable_i = 1'b1;
    opCode_i = op;
    @(posedge clock_i);
    #1;
    enable_i = 1'b0;
    opCode_i = 7'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (stall_o === 1'b1 && n < 1000) begin
      n++;
      @(posedge clock_i);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int timeouts;
    int w;
    logic found;

    reset_i   = 1'b1;
    enable_i  = 1'b0;
    opCode_i  = 7'd0;
    memAck_i  = 1'b0;
    memData_i = 16'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    for (int i = 0; i < 64; i++) rf_log[i] = 16'h0;
    repeat (3) @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    chk("rst_stall", stall_o, 0);
    chk("rst_depth", regBankSelect_o, 0);
    chk("rst_bank", physBank_o, 0);
    chk("rst_memreq", memReq_o, 0);
    chk("rst_memwe", memWe_o, 0);
    chk("rst_memaddr", memAddr_o, 0);
    chk("rst_rfaddr", rfAddr_o, 0);
    chk("rst_rfwren", rfWrEn_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_unf", underflow_o, 0);
    chk("rst_spillcnt", spillCount_o, 0);
    chk("rst_fillcnt", fillCount_o, 0);

    // Three resident pushes, no stall.
    do_op(7'd11);
    chk("push1_depth", regBankSelect_o, 1);
    chk("push1_stall", stall_o, 0);
    do_op(7'd13);
    chk("push2_depth", regBankSelect_o, 2);
    chk("push2_stall", stall_o, 0);
    do_op(7'd11);
    chk("push3_depth", regBankSelect_o, 3);
    chk("push3_bank", physBank_o, 3);
    chk("push3_stall", stall_o, 0);
    do_op(7'd5);
    chk("ignored_op_depth", regBankSelect_o, 3);

    // Fourth push spills frame 0; pops offered while stalled are ignored.
    exp_base = 16'hF000; ack_seq = 0; mem_wr_cnt = 0; addr_err = 0;
    do_op(7'd13);
    enable_i = 1'b1;
    opCode_i = 7'd12;
    repeat (3) begin @(posedge clock_i); #1; end
    enable_i = 1'b0;
    opCode_i = 7'd0;
    wait_idle(n);
    chk("spill1_stall_cycles", n + 3, 17);
    chk("spill1_depth", regBankSelect_o, 4);
    chk("spill1_bank", physBank_o, 0);
    chk("spill1_writes", mem_wr_cnt, 16);
    chk("spill1_addr_err", addr_err, 0);
    for (int k = 0; k < 16; k++) chk("spill1_data", mem[k], 16'hA500 + 16'(k));

    // Pops down to depth 1, then a fill of frame 0.
    do_op(7'd12);
    chk("pop1_depth", regBankSelect_o, 3);
    do_op(7'd14);
    chk("pop2_depth", regBankSelect_o, 2);
    do_op(7'd12);
    chk("pop3_depth", regBankSelect_o, 1);
    chk("pop3_bank", physBank_o, 1);
    chk("pop3_stall", stall_o, 0);
    exp_base = 16'hF000; ack_seq = 0; mem_wr_cnt = 0; rf_wr_cnt = 0; addr_err = 0;
    do_op(7'd14);
    chk("fill_stall_now", stall_o, 1);
    wait_idle(n);
    chk("fill_stall_cycles", n, 17);
    chk("fill_rf_writes", rf_wr_cnt, 16);
    chk("fill_mem_writes", mem_wr_cnt, 0);
    chk("fill_addr_err", addr_err, 0);
    chk("fill_depth", regBankSelect_o, 0);
    for (int k = 0; k < 16; k++) chk("fill_rf_data", rf_log[k], 16'hA500 + 16'(k));

    // Pop at depth 0.
    do_op(7'd12);
    chk("unf_flag", underflow_o, 1);
    chk("unf_depth", regBankSelect_o, 0);
    chk("unf_ovf_clear", overflow_o, 0);

    // Second spill with random ack delays.
    do_op(7'd11);
    do_op(7'd11);
    do_op(7'd11);
    chk("refill_depth", regBankSelect_o, 3);
    for (int k = 0; k < 16; k++) mem[k] = 16'h0;
    max_delay = 5; exp_base = 16'hF000; ack_seq = 0; mem_wr_cnt = 0; stab_err = 0; addr_err = 0;
    do_op(7'd13);
    wait_idle(n);
    max_delay = 0;
    chk("rand_writes", mem_wr_cnt, 16);
    chk("rand_acks", ack_seq, 16);
    chk("rand_stable", stab_err, 0);
    chk("rand_addr_err", addr_err, 0);
    chk("rand_data5", mem[5], 16'hA505);
    chk("rand_depth", regBankSelect_o, 4);
`ifdef RFC_STATS_EN
    chk("stats_spill", spillCount_o, 2);
    chk("stats_fill", fillCount_o, 1);
`else
    chk("stats_spill", spillCount_o, 0);
    chk("stats_fill", fillCount_o, 0);
`endif

    // Push to depth 63, every push spilling the oldest frame.
    timeouts = 0; addr_err = 0;
    for (int it = 0; it < 70 && regBankSelect_o != 6'd63; it++) begin
      exp_base = 16'hF000 + ((16'(regBankSelect_o) + 16'd1 - 16'd4) << 4);
      ack_seq  = 0;
      do_op(7'd11);
      wait_idle(n);
      if (n >= 1000) timeouts++;
    end
    chk("deep_depth", regBankSelect_o, 63);
    chk("deep_bank", physBank_o, 3);
    chk("deep_timeouts", timeouts, 0);
    chk("deep_addr_err", addr_err, 0);
    chk("deep_frame59_last", mem[12'h3BF], 16'hA53F);
    chk("deep_ovf_before", overflow_o, 0);
    do_op(7'd13);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_depth", regBankSelect_o, 63);
    chk("ovf_stall", stall_o, 0);

    // Reset in the middle of a spill.
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    chk("rst2_ovf", overflow_o, 0);
    chk("rst2_depth", regBankSelect_o, 0);
    do_op(7'd11);
    do_op(7'd11);
    do_op(7'd11);
    exp_base = 16'hF000; ack_seq = 0;
    do_op(7'd11);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (memReq_o === 1'b1 && rfAddr_o[3:0] === 4'd7) found = 1'b1;
      else begin @(posedge clock_i); #1; end
    end
    chk("abort_reached_idx7", found, 1);
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    chk("abort_memreq", memReq_o, 0);
    chk("abort_stall", stall_o, 0);
    chk("abort_depth", regBankSelect_o, 0);
    w = mem_wr_cnt;
    repeat (3) begin @(posedge clock_i); #1; end
    chk("abort_no_more_writes", mem_wr_cnt, w);
    chk("abort_memreq_later", memReq_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
